imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single synchronous-read instruction memory port (1-cycle read latency, 32-bit word addressed by byte address) between two requesters: the fetch stage (port 0, F) and a secondary reader such as a loader/debug or data-side read path (port 1, D). It grants at most one request per cycle and routes each read response back to its owner. It holds a response the owner cannot yet accept, and kills in-flight fetch responses on a pipeline redirect. It sits between the fetch stage and the instruction memory.

## Interface
- ADDR_W, 32, request address width (byte address)
- DATA_W, 32, instruction/data word width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- f_req_valid_i / d_req_valid_i  in  1  port request valid
- f_req_addr_i / d_req_addr_i  in  ADDR_W  byte address
- f_req_ready_o / d_req_ready_o  out  1  request accepted this cycle (valid & ready = grant)
- f_resp_valid_o / d_resp_valid_o  out  1  response word valid
- f_resp_data_o / d_resp_data_o  out  DATA_W  response word
- f_resp_ready_i / d_resp_ready_i  in  1  owner accepts response
- flush_i  in  1  fetch redirect: discard all older fetch responses
- mem_req_o  out  1  a read is issued this cycle
- mem_addr_o  out  ADDR_W  address to memory (memory samples it and returns data next cycle)
- mem_rdata_i  in  DATA_W  read data for the address issued the previous cycle

## Operation
- State: inflight_q (1b), inflight_owner_q (0=F, 1=D), hold_valid_q, hold_owner_q, hold_data_q, rr_last_q (port granted last).
- Response source: hold_data_q if hold_valid_q, else mem_rdata_i when inflight_q. Source owner's resp_valid_o=1 and data driven; the other port's resp_valid_o=0 and data=0.
- Kill: the in-flight or held response is killed if its owner is F and flush_i=1. A killed response is never presented as valid, is dropped, and frees the slot in the same cycle.
- Response drains this cycle if killed, or if its owner's resp_ready_i=1.
- can_issue = ~hold_valid_q | hold drains. If there is no hold: ~inflight_q | in-flight response drains.
- In-flight response not drained and no hold: capture into hold register (hold_valid_q<=1, owner, data).
- Arbitration when can_issue: single valid wins. If both are valid, grant the port ≠ rr_last_q and update rr_last_q on every grant. No grant when can_issue=0; both ready_o=0.
- req_ready_o is combinational from resp_ready_i and flush_i. It must not depend on req_valid of its own port, but may depend on the other port's valid.
- Grant: mem_req_o=1, mem_addr_o=granted addr, inflight_q<=1, inflight_owner_q<=port. No grant: mem_req_o=0, mem_addr_o holds last issued value, inflight_q<=0.
- A fetch request granted in the same cycle as flush_i is NOT killed. Only responses to earlier grants are killed.
- Hold and in-flight can never both be undrained. At most one response is outstanding, either in flight or held.

## Timing
- Reset (async, immediate): all *_ready_o=0, all *_resp_valid_o=0, resp data=0, mem_req_o=0, mem_addr_o=0, inflight_q=0, hold_valid_q=0, rr_last_q=1 (F wins first conflict).
- Latency: grant in cycle N, then resp_valid in cycle N+1 (direct from memory). If not accepted in N+1, the response is held and re-presented from N+2 until accepted or killed.
- Throughput: 1 grant/cycle while owners accept responses in the same cycle.
- Backpressure: a held response blocks all grants, for both ports, until it drains.
- Reset asserted mid-transaction: in-flight and held responses are discarded. After deassertion, no response is emitted for pre-reset grants.

## Test plan
- F only, addr 0x0,0x4,0x8 on consecutive cycles, resp_ready=1 → mem_addr_o 0x0/0x4/0x8 in cycles 0–2; f_resp_valid in cycles 1–3 with data matching the memory model; d_resp_valid=0 throughout.
- F and D both valid every cycle, F@0x100 and D@0x200, always ready → grants alternate F,D,F,D starting with F after reset; each response is routed to the correct port.
- F grant at 0x10 in cycle 0, f_resp_ready=0 in cycles 1–3 → response held; f_resp_valid=1 with the same data in cycles 1–4; both req_ready=0 in cycles 1–3; accepted in cycle 4 with grants resuming that cycle.
- F grant at 0x20 in cycle 0, flush_i=1 in cycle 1 with new F request 0x80 → no f_resp_valid in cycle 1; 0x80 is granted in cycle 1 and its data is returned in cycle 2 unkilled.
- D response held (d_resp_ready=0) then flush_i=1 → the D response is not killed and remains valid until accepted.
- rst_i asserted while a response is held → all outputs are at reset values immediately; no response appears after release until a new grant.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one synchronous-read instruction memory port
// between the fetch stage (port 0, F) and a secondary reader (port 1, D).
// At most one read is outstanding, either in flight from memory or parked in
// a hold register. A fetch redirect kills older fetch responses.
module imem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_valid_i,
  input  logic [ADDR_W-1:0] f_req_addr_i,
  output logic              f_req_ready_o,
  input  logic              d_req_valid_i,
  input  logic [ADDR_W-1:0] d_req_addr_i,
  output logic              d_req_ready_o,
  output logic              f_resp_valid_o,
  output logic [DATA_W-1:0] f_resp_data_o,
  input  logic              f_resp_ready_i,
  output logic              d_resp_valid_o,
  output logic [DATA_W-1:0] d_resp_data_o,
  input  logic              d_resp_ready_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Owner encoding: 0 = F, 1 = D
  logic              r_inflight;
  logic              r_inflight_owner;
  logic              r_hold_valid;
  logic              r_hold_owner;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_rr_last;
  logic [ADDR_W-1:0] r_last_addr;

  logic              w_src_valid;
  logic              w_src_owner;
  logic [DATA_W-1:0] w_src_data;
  logic              w_kill;
  logic              w_owner_rdy;
  logic              w_drain;
  logic              w_can_issue;
  logic              w_f_rdy;
  logic              w_d_rdy;
  logic              w_f_gnt;
  logic              w_d_gnt;
  logic              w_gnt;
  logic [ADDR_W-1:0] w_gnt_addr;

  // Pick the single outstanding response and decide whether it leaves this cycle
  always_comb begin
    w_src_valid = r_hold_valid | r_inflight;
    w_src_owner = r_hold_valid ? r_hold_owner : r_inflight_owner;
    w_src_data  = r_hold_valid ? r_hold_data : mem_rdata_i;
    w_kill      = w_src_valid & ~w_src_owner & flush_i;
    w_owner_rdy = w_src_owner ? d_resp_ready_i : f_resp_ready_i;
    w_drain     = w_src_valid & (w_kill | w_owner_rdy);
    // Reset gating keeps every ready/grant low while rst_i is high
    w_can_issue = ~rst_i & (~w_src_valid | w_drain);
  end

  // Round-robin grant; ready never looks at its own port's valid
  always_comb begin
    w_f_rdy    = w_can_issue & (~d_req_valid_i | r_rr_last);
    w_d_rdy    = w_can_issue & (~f_req_valid_i | ~r_rr_last);
    w_f_gnt    = w_f_rdy & f_req_valid_i;
    w_d_gnt    = w_d_rdy & d_req_valid_i;
    w_gnt      = w_f_gnt | w_d_gnt;
    w_gnt_addr = w_d_gnt ? d_req_addr_i : f_req_addr_i;
  end

  // Drive request handshakes, memory port and routed responses
  always_comb begin
    f_req_ready_o  = w_f_rdy;
    d_req_ready_o  = w_d_rdy;
    mem_req_o      = w_gnt;
    mem_addr_o     = w_gnt ? w_gnt_addr : r_last_addr;
    f_resp_valid_o = w_src_valid & ~w_kill & ~w_src_owner;
    d_resp_valid_o = w_src_valid & w_src_owner;
    f_resp_data_o  = f_resp_valid_o ? w_src_data : '0;
    d_resp_data_o  = d_resp_valid_o ? w_src_data : '0;
  end

  // Track the read issued this cycle; its data arrives next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight       <= 1'b0;
      r_inflight_owner <= 1'b0;
      r_last_addr      <= '0;
    end else begin
      r_inflight <= w_gnt;
      if (w_gnt) begin
        r_inflight_owner <= w_d_gnt;
        r_last_addr      <= w_gnt_addr;
      end
    end
  end

  // Park an unaccepted memory response; release it once it drains
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_valid <= 1'b0;
      r_hold_owner <= 1'b0;
      r_hold_data  <= '0;
    end else if (r_hold_valid) begin
      if (w_drain) r_hold_valid <= 1'b0;
    end else if (r_inflight && !w_drain) begin
      r_hold_valid <= 1'b1;
      r_hold_owner <= r_inflight_owner;
      r_hold_data  <= mem_rdata_i;
    end
  end

  // Remember the last granted port; reset favours F on the first conflict
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      r_rr_last <= 1'b1;
    else if (w_gnt) r_rr_last <= w_d_gnt;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter. Inputs change on the falling edge and
// outputs are checked 1 ns later. The memory returns 32'hC0DE0000 | addr.
module tb_imem_port_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        f_req_valid_i = 1'b0, d_req_valid_i = 1'b0;
  logic [31:0] f_req_addr_i = '0, d_req_addr_i = '0;
  logic        f_req_ready_o, d_req_ready_o;
  logic        f_resp_valid_o, d_resp_valid_o;
  logic [31:0] f_resp_data_o, d_resp_data_o;
  logic        f_resp_ready_i = 1'b1, d_resp_ready_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_req_valid_i(f_req_valid_i), .f_req_addr_i(f_req_addr_i), .f_req_ready_o(f_req_ready_o),
    .d_req_valid_i(d_req_valid_i), .d_req_addr_i(d_req_addr_i), .d_req_ready_o(d_req_ready_o),
    .f_resp_valid_o(f_resp_valid_o), .f_resp_data_o(f_resp_data_o), .f_resp_ready_i(f_resp_ready_i),
    .d_resp_valid_o(d_resp_valid_o), .d_resp_data_o(d_resp_data_o), .d_resp_ready_i(d_resp_ready_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read memory with a recognisable data pattern
  always @(posedge clk_i) if (mem_req_o) mem_rdata_i <= 32'hC0DE0000 | mem_addr_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, settle
  task automatic step(input logic fv, input logic [31:0] fa, input logic dv, input logic [31:0] da,
                      input logic frr, input logic drr, input logic fl, input logic rst);
    @(negedge clk_i);
    rst_i = rst; f_req_valid_i = fv; f_req_addr_i = fa; d_req_valid_i = dv; d_req_addr_i = da;
    f_resp_ready_i = frr; d_resp_ready_i = drr; flush_i = fl;
    #1;
  endtask

  initial begin
    // Reset state, with requests pending
    step(1, 32'h4, 1, 32'h8, 1, 1, 0, 1);
    chk("rst_f_ready", f_req_ready_o, 0);
    chk("rst_d_ready", d_req_ready_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_f_rv", f_resp_valid_o, 0);
    chk("rst_d_rv", d_resp_valid_o, 0);

    // F-only stream 0x0, 0x4, 0x8
    step(1, 32'h0, 0, 0, 1, 1, 0, 0);
    chk("t1c0_mem_req", mem_req_o, 1);
    chk("t1c0_addr", mem_addr_o, 32'h0);
    chk("t1c0_f_rv", f_resp_valid_o, 0);
    step(1, 32'h4, 0, 0, 1, 1, 0, 0);
    chk("t1c1_addr", mem_addr_o, 32'h4);
    chk("t1c1_f_rv", f_resp_valid_o, 1);
    chk("t1c1_f_data", f_resp_data_o, 32'hC0DE0000);
    chk("t1c1_d_rv", d_resp_valid_o, 0);
    step(1, 32'h8, 0, 0, 1, 1, 0, 0);
    chk("t1c2_addr", mem_addr_o, 32'h8);
    chk("t1c2_f_data", f_resp_data_o, 32'hC0DE0004);
    step(0, 32'h0, 0, 0, 1, 1, 0, 0);
    chk("t1c3_mem_req", mem_req_o, 0);
    chk("t1c3_addr_hold", mem_addr_o, 32'h8);
    chk("t1c3_f_rv", f_resp_valid_o, 1);
    chk("t1c3_f_data", f_resp_data_o, 32'hC0DE0008);
    chk("t1c3_d_rv", d_resp_valid_o, 0);
    step(0, 32'h0, 0, 0, 1, 1, 0, 0);
    chk("t1c4_f_rv", f_resp_valid_o, 0);

    // Fresh reset, then F and D contend every cycle
    step(0, 0, 0, 0, 1, 1, 0, 1);
    step(1, 32'h100, 1, 32'h200, 1, 1, 0, 0);
    chk("t2c0_f_ready", f_req_ready_o, 1);
    chk("t2c0_d_ready", d_req_ready_o, 0);
    chk("t2c0_addr", mem_addr_o, 32'h100);
    step(1, 32'h100, 1, 32'h200, 1, 1, 0, 0);
    chk("t2c1_d_ready", d_req_ready_o, 1);
    chk("t2c1_addr", mem_addr_o, 32'h200);
    chk("t2c1_f_data", f_resp_data_o, 32'hC0DE0100);
    chk("t2c1_d_rv", d_resp_valid_o, 0);
    step(1, 32'h100, 1, 32'h200, 1, 1, 0, 0);
    chk("t2c2_addr", mem_addr_o, 32'h100);
    chk("t2c2_d_rv", d_resp_valid_o, 1);
    chk("t2c2_d_data", d_resp_data_o, 32'hC0DE0200);
    chk("t2c2_f_rv", f_resp_valid_o, 0);
    chk("t2c2_f_data0", f_resp_data_o, 32'h0);
    step(1, 32'h100, 1, 32'h200, 1, 1, 0, 0);
    chk("t2c3_addr", mem_addr_o, 32'h200);
    chk("t2c3_f_data", f_resp_data_o, 32'hC0DE0100);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t2c4_d_data", d_resp_data_o, 32'hC0DE0200);
    chk("t2c4_mem_req", mem_req_o, 0);

    // F response held for three cycles; all grants blocked meanwhile
    step(1, 32'h10, 0, 0, 1, 1, 0, 0);
    chk("t3c0_addr", mem_addr_o, 32'h10);
    for (int c = 1; c <= 3; c++) begin
      step(1, 32'h14, 1, 32'h300, 0, 1, 0, 0);
      chk("t3_hold_f_rv", f_resp_valid_o, 1);
      chk("t3_hold_f_data", f_resp_data_o, 32'hC0DE0010);
      chk("t3_hold_f_ready", f_req_ready_o, 0);
      chk("t3_hold_d_ready", d_req_ready_o, 0);
      chk("t3_hold_mem_req", mem_req_o, 0);
    end
    step(1, 32'h14, 0, 0, 1, 1, 0, 0);
    chk("t3c4_f_rv", f_resp_valid_o, 1);
    chk("t3c4_f_data", f_resp_data_o, 32'hC0DE0010);
    chk("t3c4_f_ready", f_req_ready_o, 1);
    chk("t3c4_addr", mem_addr_o, 32'h14);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t3c5_f_data", f_resp_data_o, 32'hC0DE0014);

    // Flush kills the older fetch response but not the same-cycle grant
    step(1, 32'h20, 0, 0, 1, 1, 0, 0);
    chk("t4c0_addr", mem_addr_o, 32'h20);
    step(1, 32'h80, 0, 0, 1, 1, 1, 0);
    chk("t4c1_f_rv_killed", f_resp_valid_o, 0);
    chk("t4c1_f_ready", f_req_ready_o, 1);
    chk("t4c1_addr", mem_addr_o, 32'h80);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t4c2_f_rv", f_resp_valid_o, 1);
    chk("t4c2_f_data", f_resp_data_o, 32'hC0DE0080);

    // Held D response survives flush
    step(0, 0, 1, 32'h300, 1, 0, 0, 0);
    chk("t5c0_d_ready", d_req_ready_o, 1);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    chk("t5c1_d_rv", d_resp_valid_o, 1);
    chk("t5c1_d_data", d_resp_data_o, 32'hC0DE0300);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    chk("t5c2_d_rv", d_resp_valid_o, 1);
    chk("t5c2_d_data", d_resp_data_o, 32'hC0DE0300);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t5c3_d_rv", d_resp_valid_o, 1);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t5c4_d_rv", d_resp_valid_o, 0);

    // Reset while an F response is held
    step(1, 32'h40, 0, 0, 1, 1, 0, 0);
    chk("t6c0_addr", mem_addr_o, 32'h40);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6c1_f_rv", f_resp_valid_o, 1);
    step(1, 32'h44, 0, 0, 0, 1, 0, 1);
    chk("t6_rst_f_rv", f_resp_valid_o, 0);
    chk("t6_rst_f_data", f_resp_data_o, 0);
    chk("t6_rst_f_ready", f_req_ready_o, 0);
    chk("t6_rst_mem_req", mem_req_o, 0);
    chk("t6_rst_addr", mem_addr_o, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t6_post1_f_rv", f_resp_valid_o, 0);
    chk("t6_post1_d_rv", d_resp_valid_o, 0);
    step(1, 32'h44, 0, 0, 1, 1, 0, 0);
    chk("t6_post2_f_rv", f_resp_valid_o, 0);
    chk("t6_post2_addr", mem_addr_o, 32'h44);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("t6_post3_f_data", f_resp_data_o, 32'hC0DE0044);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
